// File: rtl/reaction_round_ctrl.sv
// Reaction-time round sequencer: idle blink, pseudo-random delay, timed LED test and
// result reporting (reaction ms, false start or timeout) for the LED blinker and display.
module reaction_round_ctrl #(
  parameter int TICKS_PER_MS = 100000,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DELAY_BITS   = 11,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic        waiting_to_start,
  output logic        turn_on_led_for_test,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout,
  output logic        round_done
);

  localparam int              PW           = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int              MS_MAX       = 16383;
  localparam logic [PW-1:0]   PRESC_LAST   = PW'(TICKS_PER_MS - 1);
  localparam logic [13:0]     TIMEOUT_LAST = 14'(TIMEOUT_MS - 1);
  localparam logic [13:0]     TIMEOUT_VAL  = 14'(TIMEOUT_MS);
  localparam logic [13:0]     DELAY_MIN    = 14'(DELAY_MIN_MS);

  // ms_cnt is 14 bits wide and must never wrap; a zero target would underflow target-1
  generate
    if (TIMEOUT_MS > MS_MAX || TIMEOUT_MS < 1 || DELAY_MIN_MS < 1 ||
        DELAY_MIN_MS + (32'd1 << DELAY_BITS) - 32'd1 > MS_MAX) begin : g_param_check
      $error("reaction_round_ctrl: timing parameters overflow the 14-bit ms counter");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t        state_r;
  logic [15:0]   lfsr_r;
  logic [PW-1:0] presc_r;
  logic [13:0]   ms_cnt_r;
  logic [13:0]   target_r;
  logic          start_q_r;
  logic          react_q_r;
  logic          start_rise_r;
  logic          react_rise_r;
  logic          ms_tick_s;
  logic [13:0]   target_last_s;

  assign ms_tick_s     = (presc_r == PRESC_LAST);
  assign target_last_s = target_r - 14'd1;

  // Button edge registers and free-running LFSR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q_r    <= 1'b0;
      react_q_r    <= 1'b0;
      start_rise_r <= 1'b0;
      react_rise_r <= 1'b0;
      lfsr_r       <= 16'hACE1;
    end else begin
      start_q_r    <= start_btn;
      react_q_r    <= react_btn;
      start_rise_r <= start_btn & ~start_q_r;
      react_rise_r <= react_btn & ~react_q_r;
      lfsr_r       <= lfsr_step(lfsr_r);
    end
  end

  // Round sequencer: state, ms timing and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r              <= IDLE;
      presc_r              <= {PW{1'b0}};
      ms_cnt_r             <= 14'd0;
      target_r             <= 14'd0;
      waiting_to_start     <= 1'b1;
      turn_on_led_for_test <= 1'b0;
      result_ms            <= 14'd0;
      result_valid         <= 1'b0;
      false_start          <= 1'b0;
      timeout              <= 1'b0;
      round_done           <= 1'b0;
    end else begin
      round_done <= 1'b0;
      if (ms_tick_s) begin
        presc_r  <= {PW{1'b0}};
        ms_cnt_r <= ms_cnt_r + 14'd1;
      end else begin
        presc_r  <= presc_r + PW'(1);
      end
      // Every transition below restarts the ms timebase, overriding the update above
      case (state_r)
        IDLE, DONE: begin
          if (start_rise_r) begin
            state_r          <= DELAY;
            target_r         <= DELAY_MIN + 14'(lfsr_r[DELAY_BITS-1:0]);
            presc_r          <= {PW{1'b0}};
            ms_cnt_r         <= 14'd0;
            waiting_to_start <= 1'b0;
            result_ms        <= 14'd0;
            result_valid     <= 1'b0;
            false_start      <= 1'b0;
            timeout          <= 1'b0;
          end
        end
        DELAY: begin
          if (react_rise_r) begin
            state_r     <= DONE;
            presc_r     <= {PW{1'b0}};
            ms_cnt_r    <= 14'd0;
            false_start <= 1'b1;
            round_done  <= 1'b1;
          end else if (ms_tick_s && ms_cnt_r == target_last_s) begin
            state_r              <= MEASURE;
            presc_r              <= {PW{1'b0}};
            ms_cnt_r             <= 14'd0;
            turn_on_led_for_test <= 1'b1;
          end
        end
        MEASURE: begin
          if (react_rise_r) begin
            state_r              <= DONE;
            presc_r              <= {PW{1'b0}};
            ms_cnt_r             <= 14'd0;
            turn_on_led_for_test <= 1'b0;
            result_ms            <= ms_cnt_r;
            result_valid         <= 1'b1;
            round_done           <= 1'b1;
          end else if (ms_tick_s && ms_cnt_r == TIMEOUT_LAST) begin
            state_r              <= DONE;
            presc_r              <= {PW{1'b0}};
            ms_cnt_r             <= 14'd0;
            turn_on_led_for_test <= 1'b0;
            result_ms            <= TIMEOUT_VAL;
            timeout              <= 1'b1;
            round_done           <= 1'b1;
          end
        end
        default: begin
          state_r              <= IDLE;
          waiting_to_start     <= 1'b1;
          turn_on_led_for_test <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl: outcome of each round is predicted from the round timing
// rules (target, press time) with plain arithmetic and checked cycle by cycle.
module tb_reaction_round_ctrl;

  localparam int TPM = 4, DMIN = 2, DBITS = 2, TMO = 20;
  localparam int K_VALID = 0, K_FS = 1, K_TO = 2;

  logic        clk = 1'b0;
  logic        reset, start_btn, react_btn;
  logic        waiting_to_start, turn_on_led_for_test;
  logic [13:0] result_ms;
  logic        result_valid, false_start, timeout, round_done;

  int          total = 0, bad = 0;
  int          t, m;
  logic [15:0] m_lfsr;
  logic [19:0] held, idle_vec;

  typedef struct {
    int mode;   // 0 none, 1 press at abs cycle off, 2 press at MEASURE+off, 3 pre-held + re-press
    int off;
    int kind;
    int res;
    bit ghost;
  } vec_t;
  vec_t tbl[8];

  reaction_round_ctrl #(.TICKS_PER_MS(TPM), .DELAY_MIN_MS(DMIN), .DELAY_BITS(DBITS),
                        .TIMEOUT_MS(TMO)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .react_btn(react_btn),
    .waiting_to_start(waiting_to_start), .turn_on_led_for_test(turn_on_led_for_test),
    .result_ms(result_ms), .result_valid(result_valid), .false_start(false_start),
    .timeout(timeout), .round_done(round_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Mirror of the free-running LFSR, used only to predict the delay target
  always @(posedge clk or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_step(m_lfsr);

  function automatic logic [19:0] pack(input logic w, input logic tl, input logic d,
                                       input logic v, input logic f, input logic o, input int r);
    return {w, tl, d, v, f, o, r[13:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [19:0] want);
    logic [19:0] got;
    got = {waiting_to_start, turn_on_led_for_test, round_done, result_valid, false_start,
           timeout, result_ms};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got={wait,led,done,v,fs,to,ms}=%h want=%h", name, $time, got, want);
    end
  endtask

  // One full round from IDLE/DONE; tkind<0 lets the timing model decide the outcome
  task automatic run_round(input int mode, input int off, input int tkind, input int tres,
                           input bit ghost);
    int tg, mm, k, a, kind, res, d, s;
    start_btn = 1'b0;
    react_btn = (mode == 3);
    step();
    check("held_before_start", held);
    start_btn = 1'b1;
    tg = DMIN + int'(lfsr_step(m_lfsr)) % (1 << DBITS);
    mm = TPM * tg;
    k  = (mode >= 2) ? mm + off - 2 : off;
    a  = k + 2;
    if (tkind >= 0) begin
      kind = tkind; res = tres;
    end else if (mode == 0 || a > mm + TMO * TPM) begin
      kind = K_TO; res = TMO;
    end else if (a <= mm) begin
      kind = K_FS; res = 0;
    end else begin
      kind = K_VALID; res = (a - mm - 1) / TPM;
    end
    d = (kind == K_TO) ? mm + TMO * TPM : a;
    s = (ghost && d >= 4) ? int'($urandom_range(2, d - 2)) : -1;
    step();
    check("start_edge_sampled", held);
    for (int rel = 0; rel <= d + 1; rel++) begin
      if (rel == 1) start_btn = 1'b0;
      if (rel == s) start_btn = 1'b1;
      if (mode == 3 && rel == mm + 3) react_btn = 1'b0;
      if (mode != 0 && rel == k + 1) react_btn = 1'b1;
      step();
      check(rel == d ? "round_done_edge" : "round_cycle",
            pack(1'b0, kind != K_FS && rel >= mm && rel < d, rel == d,
                 rel >= d && kind == K_VALID, rel >= d && kind == K_FS,
                 rel >= d && kind == K_TO, rel >= d ? res : 0));
    end
    held = pack(1'b0, 1'b0, 1'b0, kind == K_VALID, kind == K_FS, kind == K_TO, res);
  endtask

  initial begin
    tbl[0] = '{1, 4,  K_FS,    0,  1'b1};   // press ~1 ms into DELAY
    tbl[1] = '{2, 21, K_VALID, 5,  1'b1};   // press after 5 ms ticks
    tbl[2] = '{2, 1,  K_VALID, 0,  1'b0};   // press right after LED on
    tbl[3] = '{2, 0,  K_FS,    0,  1'b0};   // press on the DELAY expiry edge
    tbl[4] = '{2, 80, K_VALID, 19, 1'b1};   // press on the timeout tick
    tbl[5] = '{2, 81, K_TO,    20, 1'b0};   // press one cycle too late
    tbl[6] = '{0, 0,  K_TO,    20, 1'b1};   // no press at all
    tbl[7] = '{3, 10, K_VALID, 2,  1'b0};   // held into MEASURE, released, re-pressed

    idle_vec  = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset     = 1'b0;
    start_btn = 1'b0;
    react_btn = 1'b0;
    #3 reset = 1'b1;
    #1 check("reset_async", idle_vec);
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
    step();
    check("idle_after_reset", idle_vec);
    held = idle_vec;

    for (int i = 0; i < 8; i++)
      run_round(tbl[i].mode, tbl[i].off, tbl[i].kind, tbl[i].res, tbl[i].ghost);

    // Reset pulse in MEASURE, with an ignored start press just before it
    start_btn = 1'b0;
    react_btn = 1'b0;
    step();
    check("abort_held", held);
    start_btn = 1'b1;
    t = DMIN + int'(lfsr_step(m_lfsr)) % (1 << DBITS);
    m = TPM * t;
    step();
    check("abort_start_sampled", held);
    for (int rel = 0; rel <= m + 5; rel++) begin
      if (rel == 1) start_btn = 1'b0;
      if (rel == m + 1) start_btn = 1'b1;
      step();
      check("abort_round", pack(1'b0, rel >= m, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    end
    #2 reset = 1'b1;
    #1 check("reset_in_measure", idle_vec);
    start_btn = 1'b0;
    #2 reset = 1'b0;
    step();
    check("idle_after_abort", idle_vec);
    held = idle_vec;

    for (int i = 0; i < 30; i++)
      run_round(($urandom_range(0, 7) == 0) ? 0 : 1, int'($urandom_range(0, 110)), -1, 0,
                $urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
